// File: rtl/ins_prefetch.sv
// ins_prefetch: instruction prefetch queue with redirect flush.
// Define PREFETCH_BYPASS_EN to present imem_data directly when the queue is empty.
module ins_prefetch #(
  parameter int DEPTH = 4,
  parameter int IAW = 8
) (
  input  logic                    clk,
  input  logic                    rstd,
  output logic [IAW-1:0]          imem_addr,
  input  logic [31:0]             imem_data,
  output logic                    out_valid,
  output logic [31:0]             out_ins,
  output logic [31:0]             out_pc,
  input  logic                    out_ready,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] fetch_pc;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic empty, byp, pop, push, store, deq;
  assign empty = count == '0;
  assign imem_addr = fetch_pc[IAW-1:0];
`ifdef PREFETCH_BYPASS_EN
  assign byp = rstd && empty && !redirect;
  assign out_valid = !empty || byp;
  assign out_ins = byp ? imem_data : empty ? '0 : ins_mem[rd_ptr];
  assign out_pc = byp ? fetch_pc : empty ? '0 : pc_mem[rd_ptr];
`else
  assign byp = 1'b0;
  assign out_valid = !empty;
  assign out_ins = empty ? '0 : ins_mem[rd_ptr];
  assign out_pc = empty ? '0 : pc_mem[rd_ptr];
`endif
  assign pop = out_valid && out_ready;
  assign push = !redirect && (count != FULL || pop);
  // a bypassed word taken by execute is never written into the queue
  assign store = push && !(byp && out_ready);
  assign deq = pop && !byp;
  always_ff @(posedge clk or negedge rstd)
    if (!rstd) begin
      fetch_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) fetch_pc <= fetch_pc + 32'd1;
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(store) - (AW+1)'(deq);
    end
  always_ff @(posedge clk)
    if (store) begin
      pc_mem[wr_ptr] <= fetch_pc;
      ins_mem[wr_ptr] <= imem_data;
    end
endmodule

// File: tb/tb_ins_prefetch.sv
// tb_ins_prefetch: directed stimulus with a queue scoreboard checking every delivered instruction.
module tb_ins_prefetch;
  localparam int DEPTH = 4;
  localparam int IAW = 8;
`ifdef PREFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstd = 1'b1;
  logic [IAW-1:0] imem_addr;
  logic [31:0] imem_data;
  logic out_valid;
  logic [31:0] out_ins, out_pc;
  logic out_ready = 1'b0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [$clog2(DEPTH):0] count;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  ins_prefetch #(.DEPTH(DEPTH), .IAW(IAW)) dut (
    .clk(clk), .rstd(rstd), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc), .out_ready(out_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;
  assign imem_data = 32'(imem_addr) + 32'd100;

  always @(negedge clk)
    if (rstd && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop got pc=%h required no delivery", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e) begin
          n_fail++;
          $display("FAIL pop_pc got %h required %h", out_pc, e);
        end
        n_chk++;
        if (out_ins !== {24'd0, e[7:0]} + 32'd100) begin
          n_fail++;
          $display("FAIL pop_ins got %h required %h", out_ins, {24'd0, e[7:0]} + 32'd100);
        end
      end
    end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic rst;
    rstd = 1'b0;
    exp_q.delete();
    step;
    step;
    rstd = 1'b1;
  endtask

  task automatic expect_range(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1 rstd = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ins", out_ins, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", 32'(imem_addr), 0);
    step;
    step;
    // stream with out_ready held high
    expect_range(0, 8);
    out_ready = 1'b1;
    rstd = 1'b1;
    #1;
    chk("a_first_valid", 32'(out_valid), 32'(BYP));
    for (int i = 0; i < 6; i++) begin
      step;
      chk("a_no_gap", 32'(out_valid), 1);
    end
    drain("a_drain");
    out_ready = 1'b0;
    // fill to capacity, then release
    rst;
    repeat (10) step;
    chk("b_count_full", 32'(count), DEPTH);
    chk("b_addr_hold", 32'(imem_addr), 4);
    chk("b_head_pc", out_pc, 0);
    expect_range(0, 6);
    out_ready = 1'b1;
    drain("b_drain");
    out_ready = 1'b0;
    // redirect while pc 5 is popped
    rst;
    expect_range(0, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !(out_valid && out_pc == 32'd5); i++) step;
    chk("c_head5", out_pc, 5);
    if (!BYP) exp_q.push_back(32'd5);
    expect_range(32'h40, 4);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step;
    redirect = 1'b0;
    chk("c_count0", 32'(count), 0);
    chk("c_valid", 32'(out_valid), 32'(BYP));
    step;
    chk("c_pc40", out_pc, BYP ? 32'h41 : 32'h40);
    drain("c_drain");
    out_ready = 1'b0;
    // back-to-back redirects, last wins
    rst;
    repeat (3) step;
    redirect = 1'b1;
    redirect_pc = 32'h10;
    step;
    redirect_pc = 32'h20;
    step;
    redirect = 1'b0;
    chk("d_count0", 32'(count), 0);
    chk("d_addr20", 32'(imem_addr), 32'h20);
    expect_range(32'h20, 4);
    out_ready = 1'b1;
    drain("d_drain");
    out_ready = 1'b0;
    // asynchronous reset mid-stream
    rst;
    repeat (3) step;
    chk("e_count3", 32'(count), 3);
    #2 rstd = 1'b0;
    #1;
    chk("e_async_count", 32'(count), 0);
    chk("e_async_valid", 32'(out_valid), 0);
    chk("e_async_addr", 32'(imem_addr), 0);
    chk("e_async_pc", out_pc, 0);
    // fetch_pc wrap
    rst;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step;
    redirect = 1'b0;
    chk("f_addr_fe", 32'(imem_addr), 32'hFE);
    step;
    chk("f_addr_ff", 32'(imem_addr), 32'hFF);
    step;
    chk("f_addr_00", 32'(imem_addr), 32'h00);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    out_ready = 1'b1;
    drain("f_drain");
    out_ready = 1'b0;
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
